// File: rtl/spi_mem_pkg.sv
// Shared types and sizing helpers for the burst SPI memory.
// Holds the FSM state enum and the header/counter width functions.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        READ,
        WRITE
    } state_t;

    // Header frame is {addr, rw}.
    function automatic int hdr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter must hold values up to the longest frame length.
    function automatic int cnt_w(input int addr_w, input int data_w);
        return $clog2(max_i(addr_w + 1, data_w) + 1);
    endfunction

endpackage

// File: rtl/spi_memory_burst_sync.sv
// spi_pin_sync: multi-stage synchronizer for one SPI pin.
// Ports: clk, reset_n, pin_i -> level_o (synced), rise_o/fall_o (1-clk pulses).
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a cs held low through reset never looks
    // like a falling edge; only a fresh high->low starts a transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave memory with {addr,rw} header and auto-increment bursts.
// Ports: clk, reset_n, sclk_pin/cs_pin/mosi_pin in; miso, miso_oe, busy, cur_addr out.
module spi_memory_burst
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 2 ** ADDR_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk_pin,
    input  logic              cs_pin,
    input  logic              mosi_pin,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int HDR_W = hdr_w(ADDR_W);
    localparam int CNT_W = cnt_w(ADDR_W, DATA_W);
    localparam int SR_W  = max_i(HDR_W, DATA_W);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_ok;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .pin_i(sclk_pin),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .pin_i(cs_pin),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .pin_i(mosi_pin),
        .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_ok = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SR_W-1:0]     rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic                ld_q, ld_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic hdr_last, word_last;
    assign hdr_last  = (cnt_q == CNT_W'(HDR_W - 1));
    assign word_last = (cnt_q == CNT_W'(DATA_W - 1));

    function automatic logic [ADDR_W-1:0] addr_mod(input logic [ADDR_W-1:0] a);
        return ADDR_W'(32'(a) % DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (32'(a) >= DEPTH - 1) ? '0 : a + ADDR_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; cs rise overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (cs_fall) state_d = HEADER;
            HEADER: if (sclk_rise && hdr_last)
                        state_d = mosi_s ? READ : WRITE;
            READ:   ;
            WRITE:  ;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    // Datapath next-state; a final write bit coinciding with cs rise
    // still raises we_d, so the word commits on the following clk.
    always_comb begin
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        ld_d    = 1'b0;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    cnt_d = '0;
                    rx_d  = '0;
                end
            end
            HEADER: begin
                if (sclk_rise) begin
                    rx_d  = {rx_q[SR_W-2:0], mosi_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (hdr_last) begin
                        cnt_d  = '0;
                        addr_d = addr_mod(rx_q[HDR_W-2:0]);
                        ld_d   = mosi_s;
                    end
                end
            end
            READ: begin
                if (ld_q) tx_d = rdata_q;
                if (sclk_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    oe_d   = 1'b1;
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (word_last) begin
                        cnt_d  = '0;
                        addr_d = addr_inc(addr_q);
                        ld_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (sclk_rise) begin
                    rx_d  = {rx_q[SR_W-2:0], mosi_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (word_last) begin
                        cnt_d   = '0;
                        we_d    = 1'b1;
                        wdata_d = {rx_q[DATA_W-2:0], mosi_s};
                        waddr_d = addr_q;
                        addr_d  = addr_inc(addr_q);
                    end
                end
            end
        endcase
        if (cs_rise) begin
            cnt_d  = '0;
            oe_d   = 1'b0;
            miso_d = 1'b0;
            ld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            ld_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            ld_q    <= ld_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    // Read indexes addr_d so data for a new address is ready when ld_q fires.
    always_ff @(posedge clk) begin
        if (we_q) mem[waddr_q] <= wdata_q;
        rdata_q <= mem[addr_d];
    end

    // Outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    assign miso     = miso_q;
    assign miso_oe  = oe_q;
    assign cur_addr = addr_q;

endmodule
